// File: rtl/maxunpool_stream_if.sv
// Stream bundle for the 2x2 max-unpool block: pooled-element input side,
// frame control/status and the full unpooled tensor output.
interface maxunpool_stream_if #(
  parameter int IN_DIM = 12,
  parameter int DW     = 8
);
  localparam int TW = (2*IN_DIM)*(2*IN_DIM)*DW;

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_idx;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] tensor_out;

  modport master (
    output start, in_valid, in_data, in_idx, out_ready,
    input  in_ready, busy, out_valid, tensor_out
  );

  modport slave (
    input  start, in_valid, in_data, in_idx, out_ready,
    output in_ready, busy, out_valid, tensor_out
  );
endinterface

// File: rtl/maxunpool_stream.sv
// Sequential 2x2 max-unpool: each pooled value lands at its argmax slot of the
// matching 2x2 window in a zero-cleared (2*IN_DIM)^2 tensor.
module maxunpool_stream #(
  parameter int IN_DIM = 12,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxunpool_stream_if.slave    bus
);
  localparam int OD = 2*IN_DIM;
  localparam int TW = OD*OD*DW;
  localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int EW = $clog2(OD*OD);
  localparam int BW = $clog2(TW);
  localparam logic [CW-1:0] LAST = CW'(IN_DIM-1);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [TW-1:0]   tensor_q;

  logic            clear;
  logic            beat;
  logic [CW:0]     wr_r;
  logic [CW:0]     wr_c;
  logic [EW-1:0]   elem;
  logic [BW-1:0]   bit_off;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    clear   = 1'b0;
    beat    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        clear   = 1'b1;
        row_d   = '0;
        col_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        beat = bus.in_valid;
        if (beat) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window origin is (2*row, 2*col); the index bits supply the in-window offset.
  always_comb begin
    wr_r    = {row_q, bus.in_idx[1]};
    wr_c    = {col_q, bus.in_idx[0]};
    elem    = EW'(wr_r) * EW'(OD) + EW'(wr_c);
    bit_off = BW'(elem) * BW'(DW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tensor_q <= '0;
    end else if (clear) begin
      tensor_q <= '0;
    end else if (beat) begin
      tensor_q[bit_off +: DW] <= bus.in_data;
    end
  end

  assign bus.in_ready   = (state_q == FILL);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.tensor_out = tensor_q;
endmodule

// File: tb/tb_maxunpool_stream.sv
// Self-checking bench for maxunpool_stream: scoreboard of placed elements plus
// a table of argmax-index placement vectors.
module tb_maxunpool_stream;
  localparam int IN_DIM = 12;
  localparam int DW     = 8;
  localparam int OD     = 2*IN_DIM;
  localparam int NBEAT  = IN_DIM*IN_DIM;

  logic clk;
  logic rst_n;

  maxunpool_stream_if #(.IN_DIM(IN_DIM), .DW(DW)) dut_if ();

  maxunpool_stream #(.IN_DIM(IN_DIM), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned r;
    int unsigned c;
    logic [7:0]  d;
  } sb_t;

  typedef struct {
    logic [1:0]  idx;
    logic [7:0]  data;
    int unsigned off;
  } vec_t;

  sb_t          sbq[$];
  vec_t         tbl[4];
  logic [7:0]   model[OD][OD];
  int           checks;
  int           failures;
  logic [1:0]   first_idx;
  logic [7:0]   first_data;
  logic [OD*OD*DW-1:0] snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] elem_at(input int unsigned r, input int unsigned c);
    return dut_if.tensor_out[(r*OD+c)*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pattern 0: data k+1, idx 0; 1: table vector on beat 0 then zeros;
  // 2: data 0xC0^k, idx 3
  task automatic send_frame(input int pattern, input bit throttle);
    int unsigned k;
    int unsigned cyc;
    int unsigned early;
    logic [7:0]  d;
    logic [1:0]  ix;
    for (int unsigned r = 0; r < OD; r++)
      for (int unsigned c = 0; c < OD; c++)
        model[r][c] = 8'h00;
    dut_if.start = 1'b1;
    tick();
    dut_if.start = 1'b0;
    chk("clear_busy", {31'd0, dut_if.busy}, 32'd1);
    chk("clear_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    tick();
    chk("fill_in_ready", {31'd0, dut_if.in_ready}, 32'd1);
    k = 0; cyc = 0; early = 0;
    while (k < NBEAT && cyc < 4000) begin
      if (dut_if.out_valid) early++;
      case (pattern)
        0:       begin d = 8'(k + 1);        ix = 2'd0; end
        1:       begin d = (k == 0) ? first_data : 8'h00;
                       ix = (k == 0) ? first_idx : 2'($urandom_range(3)); end
        default: begin d = 8'hC0 ^ 8'(k);   ix = 2'd3; end
      endcase
      dut_if.in_valid = throttle ? (cyc % 2 == 0) : 1'b1;
      dut_if.in_data  = d;
      dut_if.in_idx   = ix;
      if (dut_if.in_valid && dut_if.in_ready) begin
        sbq.push_back('{r: 2*(k/IN_DIM) + ix[1], c: 2*(k%IN_DIM) + ix[0], d: d});
        model[2*(k/IN_DIM) + ix[1]][2*(k%IN_DIM) + ix[0]] = d;
        k++;
      end
      tick();
      cyc++;
    end
    dut_if.in_valid = 1'b0;
    chk("beats_accepted", k, NBEAT);
    chk("early_out_valid", early, 0);
    chk("out_valid_latency", {31'd0, dut_if.out_valid}, 32'd1);
    chk("done_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
  endtask

  task automatic check_frame();
    int unsigned bad;
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("elem_%0d_%0d", e.r, e.c), {24'd0, elem_at(e.r, e.c)}, {24'd0, e.d});
    end
    bad = 0;
    for (int unsigned r = 0; r < OD; r++)
      for (int unsigned c = 0; c < OD; c++)
        if (elem_at(r, c) !== model[r][c]) bad++;
    chk("whole_tensor_mismatches", bad, 0);
  endtask

  task automatic handoff();
    dut_if.out_ready = 1'b1;
    tick();
    dut_if.out_ready = 1'b0;
    chk("handoff_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    chk("handoff_busy", {31'd0, dut_if.busy}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    tbl[0] = '{idx: 2'd0, data: 8'hA5, off: 0};
    tbl[1] = '{idx: 2'd1, data: 8'hA5, off: 8};
    tbl[2] = '{idx: 2'd2, data: 8'hA5, off: 192};
    tbl[3] = '{idx: 2'd3, data: 8'hA5, off: 200};

    rst_n = 1'b0;
    dut_if.start = 1'b0; dut_if.in_valid = 1'b0; dut_if.in_data = '0;
    dut_if.in_idx = '0; dut_if.out_ready = 1'b0;
    first_idx = '0; first_data = '0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    chk("rst_busy", {31'd0, dut_if.busy}, 32'd0);
    chk("rst_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    chk("rst_tensor_zero", {31'd0, |dut_if.tensor_out}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, dut_if.busy}, 32'd0);

    // Single frame, idx 0, data k+1; then hold in DONE with a stray start.
    send_frame(0, 1'b0);
    chk("elem_0_0", {24'd0, elem_at(0, 0)}, 32'd1);
    chk("elem_22_22", {24'd0, elem_at(22, 22)}, 32'd144);
    chk("elem_2_4", {24'd0, elem_at(2, 4)}, 32'd15);
    chk("elem_1_1_zero", {24'd0, elem_at(1, 1)}, 32'd0);
    check_frame();
    snap = dut_if.tensor_out;
    for (int unsigned i = 0; i < 10; i++) begin
      dut_if.start = (i == 4);
      tick();
      chk("done_hold_valid", {31'd0, dut_if.out_valid}, 32'd1);
      chk("done_hold_stable", {31'd0, dut_if.tensor_out == snap}, 32'd1);
    end
    dut_if.start = 1'b1;
    dut_if.out_ready = 1'b1;
    tick();
    dut_if.start = 1'b0;
    dut_if.out_ready = 1'b0;
    chk("handoff_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    tick();
    chk("start_with_ready_ignored", {31'd0, dut_if.busy}, 32'd0);
    chk("tensor_retained", {31'd0, dut_if.tensor_out == snap}, 32'd1);

    // Back-to-back frame with idx 3: no residue from frame 1.
    send_frame(2, 1'b0);
    chk("f2_elem_0_0_cleared", {24'd0, elem_at(0, 0)}, 32'd0);
    chk("f2_elem_1_1", {24'd0, elem_at(1, 1)}, 32'd192);
    check_frame();
    handoff();

    // Throttled input.
    send_frame(0, 1'b1);
    check_frame();
    handoff();

    // Index-decode table.
    for (int unsigned i = 0; i < 4; i++) begin
      first_idx  = tbl[i].idx;
      first_data = tbl[i].data;
      send_frame(1, 1'b0);
      for (int unsigned j = 0; j < 4; j++)
        chk($sformatf("idx%0d_off%0d", i, tbl[j].off),
            {24'd0, dut_if.tensor_out[tbl[j].off +: 8]},
            (j == i) ? {24'd0, tbl[i].data} : 32'd0);
      check_frame();
      handoff();
    end

    // Reset asserted mid-FILL clears outputs immediately.
    dut_if.start = 1'b1;
    tick();
    dut_if.start = 1'b0;
    tick();
    dut_if.in_valid = 1'b1; dut_if.in_data = 8'h5A; dut_if.in_idx = 2'd0;
    repeat (20) tick();
    dut_if.in_valid = 1'b0;
    chk("pre_rst_tensor_nonzero", {31'd0, |dut_if.tensor_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, dut_if.busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    chk("midrst_tensor_zero", {31'd0, |dut_if.tensor_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, dut_if.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
